// File: rtl/mips_seq_ctrl.sv
// Multicycle phase sequencer for the MIPS datapath: walks each instruction through
// FETCH/EXEC/MEM/MULDIV/WB, honours Avalon waitrequest and latches the halt condition.
module mips_seq_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic       next_pc_zero,
  output logic [2:0] state,
  output logic       read,
  output logic       write,
  output logic       ir_load,
  output logic       pc_write,
  output logic       reg_wr_phase,
  output logic       muldiv_start,
  output logic       hilo_wren,
  output logic       active,
  output logic       halted
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_MULDIV = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;

  logic is_load, is_store, is_muldiv, is_div;
  logic read_c, write_c, ir_load_c, pc_write_c, reg_wr_c, mstart_c, hilo_c;

  assign is_load   = (opcode >= 6'd32) && (opcode <= 6'd38);
  assign is_store  = (opcode == 6'd40) || (opcode == 6'd41) || (opcode == 6'd43);
  assign is_muldiv = (opcode == 6'd0) && (function_code >= 6'd24) && (function_code <= 6'd27);
  assign is_div    = function_code[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    read_c     = 1'b0;
    write_c    = 1'b0;
    ir_load_c  = 1'b0;
    pc_write_c = 1'b0;
    reg_wr_c   = 1'b0;
    mstart_c   = 1'b0;
    hilo_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        read_c = 1'b1;
        if (!waitrequest) begin
          ir_load_c = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_muldiv) begin
          mstart_c = 1'b1;
          cnt_d    = is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
          state_d  = S_MULDIV;
        end else begin
          reg_wr_c   = 1'b1;
          pc_write_c = 1'b1;
          state_d    = next_pc_zero ? S_HALT : S_FETCH;
        end
      end
      S_MEM: begin
        // Strobe is Moore on the opcode so it stays put across a stall.
        read_c  = is_load;
        write_c = is_store;
        if (!waitrequest) begin
          if (is_store) begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MULDIV: begin
        if (cnt_q == '0) begin
          hilo_c     = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB: begin
        reg_wr_c   = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign halted_d = halted_q | (state_d == S_HALT);

  // Strobes are suppressed while reset is held so nothing partial commits.
  assign state        = state_q;
  assign read         = read_c     & ~reset;
  assign write        = write_c    & ~reset;
  assign ir_load      = ir_load_c  & ~reset;
  assign pc_write     = pc_write_c & ~reset;
  assign reg_wr_phase = reg_wr_c   & ~reset;
  assign muldiv_start = mstart_c   & ~reset;
  assign hilo_wren    = hilo_c     & ~reset;
  assign active       = (state_q != S_HALT);
  assign halted       = halted_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Cycle-scripted bench for mips_seq_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared against the DUT mid-cycle.
module tb_mips_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       waitrequest = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] function_code = '0;
  logic       next_pc_zero = 1'b0;
  logic [2:0] state;
  logic       read, write, ir_load, pc_write, reg_wr_phase, muldiv_start, hilo_wren, active, halted;

  typedef struct {
    logic [11:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [2:0] FE = 3'd0, EX = 3'd1, ME = 3'd2, MD = 3'd3, WB = 3'd4, HA = 3'd5;

  mips_seq_ctrl #(.MULT_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .opcode(opcode),
    .function_code(function_code), .next_pc_zero(next_pc_zero), .state(state),
    .read(read), .write(write), .ir_load(ir_load), .pc_write(pc_write),
    .reg_wr_phase(reg_wr_phase), .muldiv_start(muldiv_start), .hilo_wren(hilo_wren),
    .active(active), .halted(halted)
  );

  always #5 clk = ~clk;

  // Field order: state, read, write, ir_load, pc_write, reg_wr, mstart, hilo, active, halted
  function automatic logic [11:0] ev(logic [2:0] st, logic rd, logic wr, logic ir, logic pcw,
                                     logic rw, logic ms, logic hl, logic act, logic hlt);
    return {st, rd, wr, ir, pcw, rw, ms, hl, act, hlt};
  endfunction

  // Drive one cycle's inputs, queue its expectation, compare at the falling edge.
  task automatic step(input logic rst, input logic wr, input logic [5:0] op,
                      input logic [5:0] fn, input logic npz, input logic [11:0] e,
                      input string name);
    exp_t x;
    logic [11:0] got;
    reset = rst; waitrequest = wr; opcode = op; function_code = fn; next_pc_zero = npz;
    exp_q.push_back('{vec: e, name: name});
    @(negedge clk);
    got = {state, read, write, ir_load, pc_write, reg_wr_phase, muldiv_start, hilo_wren,
           active, halted};
    x = exp_q.pop_front();
    checks++;
    if (got !== x.vec) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b", x.name, $time, got, x.vec);
    end else begin
      $display("ok   %s t=%0t outputs=%b", x.name, $time, got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 6'd35, 6'd0, 0, ev(FE,0,0,0,0,0,0,0,1,0), "reset_hold");
    step(1, 1, 6'd43, 6'd0, 0, ev(FE,0,0,0,0,0,0,0,1,0), "reset_hold2");
  endtask

  task automatic test_other(input logic [5:0] op, input logic [5:0] fn, input string nm);
    step(0, 0, op, fn, 0, ev(FE,1,0,1,0,0,0,0,1,0), {nm, "_fetch"});
    step(0, 1, op, fn, 0, ev(EX,0,0,0,1,1,0,0,1,0), {nm, "_exec"});
  endtask

  task automatic test_load_stall();
    step(0, 0, 6'd35, 6'd0, 0, ev(FE,1,0,1,0,0,0,0,1,0), "lw_fetch");
    step(0, 1, 6'd35, 6'd0, 0, ev(EX,0,0,0,0,0,0,0,1,0), "lw_exec");
    for (int i = 0; i < 3; i++)
      step(0, 1, 6'd35, 6'd0, 0, ev(ME,1,0,0,0,0,0,0,1,0), "lw_mem_stall");
    step(0, 0, 6'd35, 6'd0, 0, ev(ME,1,0,0,0,0,0,0,1,0), "lw_mem_done");
    step(0, 1, 6'd35, 6'd0, 0, ev(WB,0,0,0,1,1,0,0,1,0), "lw_wb");
  endtask

  task automatic test_store_fetch_stall();
    step(0, 1, 6'd43, 6'd0, 0, ev(FE,1,0,0,0,0,0,0,1,0), "sw_fetch_stall1");
    step(0, 1, 6'd43, 6'd0, 0, ev(FE,1,0,0,0,0,0,0,1,0), "sw_fetch_stall2");
    step(0, 0, 6'd43, 6'd0, 0, ev(FE,1,0,1,0,0,0,0,1,0), "sw_fetch_go");
    step(0, 0, 6'd43, 6'd0, 0, ev(EX,0,0,0,0,0,0,0,1,0), "sw_exec");
    step(0, 0, 6'd43, 6'd0, 0, ev(ME,0,1,0,1,0,0,0,1,0), "sw_mem");
  endtask

  task automatic test_muldiv(input logic [5:0] fn, input int lat, input string nm);
    step(0, 0, 6'd0, fn, 0, ev(FE,1,0,1,0,0,0,0,1,0), {nm, "_fetch"});
    step(0, 1, 6'd0, fn, 0, ev(EX,0,0,0,0,0,1,0,1,0), {nm, "_exec"});
    for (int i = 0; i < lat; i++) begin
      logic last;
      last = (i == lat - 1);
      step(0, 1'($urandom_range(0, 1)), 6'd0, fn, 0, ev(MD,0,0,0,last,0,0,last,1,0),
           last ? {nm, "_muldiv_last"} : {nm, "_muldiv"});
    end
  endtask

  task automatic test_halt();
    step(0, 0, 6'd0, 6'd8, 1, ev(FE,1,0,1,0,0,0,0,1,0), "jr_fetch");
    step(0, 0, 6'd0, 6'd8, 1, ev(EX,0,0,0,1,1,0,0,1,0), "jr_exec_halt");
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom_range(0, 1)), 6'd35, 6'd0, 0, ev(HA,0,0,0,0,0,0,0,0,1), "halt_hold");
    step(1, 0, 6'd0, 6'd0, 0, ev(HA,0,0,0,0,0,0,0,0,1), "halt_reset_cycle");
  endtask

  task automatic test_reset_mid_mem();
    step(0, 0, 6'd43, 6'd0, 0, ev(FE,1,0,1,0,0,0,0,1,0), "rst_sw_fetch");
    step(0, 0, 6'd43, 6'd0, 0, ev(EX,0,0,0,0,0,0,0,1,0), "rst_sw_exec");
    step(0, 1, 6'd43, 6'd0, 0, ev(ME,0,1,0,0,0,0,0,1,0), "rst_sw_mem_stall");
    step(1, 1, 6'd43, 6'd0, 0, ev(ME,0,0,0,0,0,0,0,1,0), "rst_sw_mem_reset");
    step(0, 1, 6'd43, 6'd0, 0, ev(FE,1,0,0,0,0,0,0,1,0), "rst_after_mem");
    step(0, 0, 6'd0, 6'd24, 0, ev(FE,1,0,1,0,0,0,0,1,0), "rst_mult_fetch");
    step(0, 0, 6'd0, 6'd24, 0, ev(EX,0,0,0,0,0,1,0,1,0), "rst_mult_exec");
    step(0, 0, 6'd0, 6'd24, 0, ev(MD,0,0,0,0,0,0,0,1,0), "rst_mult_md");
    step(1, 0, 6'd0, 6'd24, 0, ev(MD,0,0,0,0,0,0,0,1,0), "rst_mult_reset");
    step(0, 0, 6'd0, 6'd33, 0, ev(FE,1,0,1,0,0,0,0,1,0), "rst_after_md");
  endtask

  initial begin
    test_reset();
    test_other(6'd0, 6'd33, "addu");
    test_load_stall();
    test_store_fetch_stall();
    test_muldiv(6'd26, 32, "div");
    test_muldiv(6'd24, 4, "mult");
    test_muldiv(6'd27, 32, "divu");
    test_muldiv(6'd25, 4, "multu");
    test_other(6'd63, 6'd0, "unknown_op");
    test_other(6'd0, 6'd28, "funct28_other");
    test_halt();
    test_reset_mid_mem();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
